oam_access_ctrl: RTL and testbench

- Sequences all accesses to the PPU's 256x16 / 128x32 object-attribute RAM. Port A is 16-bit read/write, port B is 32-bit read-only.
- Converts CPU byte-wide register traffic into word writes and byte reads on port A. Mirrored high-table accesses go to an external 32-byte table.
- Streams OAM entries through port B to the sprite evaluator each scanline, with valid/ready backpressure and priority rotation.

---
 rtl/oam_access_ctrl_pkg.sv | 21 ++
 rtl/oam_scan_seq.sv | 91 +++++++++
 rtl/oam_access_ctrl.sv | 160 ++++++++++++++++
 tb/tb_oam_access_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/oam_access_ctrl_pkg.sv
// Shared definitions for the OAM access controller: CPU register map,
// high-table base address and the object scan state encoding.
package oam_access_ctrl_pkg;

  localparam int unsigned BYTE_AW = 10;
  localparam int unsigned WORD_AW = 8;
  localparam int unsigned OBJ_IW  = 7;

  localparam logic [15:0] OAMADD_LO = 16'h2102;
  localparam logic [15:0] OAMADD_HI = 16'h2103;
  localparam logic [15:0] OAMDATA_W = 16'h2104;
  localparam logic [15:0] OAMDATA_R = 16'h2138;

  localparam logic [BYTE_AW-1:0] OAM_HI_BASE = 10'h200;

  typedef enum logic {
    SCAN_IDLE = 1'b0,
    SCAN_RUN  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/oam_scan_seq.sv
// Streams NUM_OBJ OAM entries from RAM port B to the sprite evaluator,
// starting at a rotatable index, with valid/ready backpressure.
module oam_scan_seq
  import oam_access_ctrl_pkg::*;
#(
  parameter int unsigned NUM_OBJ = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              line_start,
  input  logic [OBJ_IW-1:0] start_idx,
  input  logic              obj_ready,
  input  logic [31:0]       ram_q_b,
  output logic [OBJ_IW-1:0] ram_address_b,
  output logic              ram_enable_b,
  output logic              obj_valid,
  output logic [OBJ_IW-1:0] obj_index,
  output logic [31:0]       obj_data,
  output logic              obj_last,
  output logic              scan_busy
);

  localparam int unsigned CNT_W = 8;

  scan_state_e       state_q, state_d;
  logic [OBJ_IW-1:0] addr_q, addr_d;
  logic [OBJ_IW-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              advance;
  logic              issue;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SCAN_IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  // A read is issued only when the output slot is free or being emptied,
  // so the RAM output (and obj_data) stays frozen while stalled.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    last_d  = last_q;
    advance = !valid_q || obj_ready;
    issue   = (state_q == SCAN_RUN) && (cnt_q < CNT_W'(NUM_OBJ)) && advance;
    if (line_start) begin
      state_d = SCAN_RUN;
      addr_d  = start_idx;
      cnt_d   = '0;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else if (state_q == SCAN_RUN) begin
      if (advance) begin
        valid_d = issue;
        last_d  = issue && (cnt_q == CNT_W'(NUM_OBJ - 1));
        if (issue) idx_d = addr_q;
      end
      if (issue) begin
        addr_d = addr_q + OBJ_IW'(1);
        cnt_d  = cnt_q + CNT_W'(1);
      end
      if (valid_q && obj_ready && last_q) state_d = SCAN_IDLE;
    end
  end

  assign ram_address_b = addr_q;
  assign ram_enable_b  = issue;
  assign obj_valid     = valid_q;
  assign obj_index     = idx_q;
  assign obj_data      = ram_q_b;
  assign obj_last      = last_q;
  assign scan_busy     = (state_q == SCAN_RUN);

endmodule

// File: rtl/oam_access_ctrl.sv
// OAM access controller: CPU byte register traffic onto the 16-bit port A
// and the mirrored high table, plus the per-line object scan on port B.
module oam_access_ctrl
  import oam_access_ctrl_pkg::*;
#(
  parameter int unsigned NUM_OBJ = 128
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               oamadd_lo_we,
  input  logic               oamadd_hi_we,
  input  logic               oamdata_we,
  input  logic               oamdata_re,
  input  logic [7:0]         cpu_din,
  output logic [7:0]         cpu_dout,
  input  logic               render_active,
  input  logic               vblank_start,
  input  logic               line_start,
  output logic [WORD_AW-1:0] ram_address_a,
  output logic [15:0]        ram_data_a,
  output logic               ram_enable_a,
  output logic               ram_wren_a,
  input  logic [15:0]        ram_q_a,
  output logic [4:0]         hi_addr,
  output logic [7:0]         hi_din,
  output logic               hi_we,
  input  logic [7:0]         hi_q,
  output logic [OBJ_IW-1:0]  ram_address_b,
  output logic               ram_enable_b,
  input  logic [31:0]        ram_q_b,
  output logic               obj_valid,
  input  logic               obj_ready,
  output logic [OBJ_IW-1:0]  obj_index,
  output logic [31:0]        obj_data,
  output logic               obj_last,
  output logic               scan_busy
);

  logic [8:0]         reload_q, reload_d;
  logic               prio_en_q, prio_en_d;
  logic [BYTE_AW-1:0] byte_addr_q, byte_addr_d;
  logic [7:0]         latch_q, latch_d;
  logic               rd_pend_q, rd_pend_d;
  logic               rd_sel_q, rd_sel_d;
  logic               rd_hi_q, rd_hi_d;
  logic [7:0]         hi_rd_q, hi_rd_d;
  logic [7:0]         dout_hold_q, dout_hold_d;
  logic               addr_ld, vb_ld, wr_go, rd_go, is_hi;
  logic [OBJ_IW-1:0]  start_idx;

  always_ff @(posedge clock) begin
    if (reset) begin
      reload_q    <= '0;
      prio_en_q   <= 1'b0;
      byte_addr_q <= '0;
      latch_q     <= '0;
      rd_pend_q   <= 1'b0;
      rd_sel_q    <= 1'b0;
      rd_hi_q     <= 1'b0;
      hi_rd_q     <= '0;
      dout_hold_q <= '0;
    end else begin
      reload_q    <= reload_d;
      prio_en_q   <= prio_en_d;
      byte_addr_q <= byte_addr_d;
      latch_q     <= latch_d;
      rd_pend_q   <= rd_pend_d;
      rd_sel_q    <= rd_sel_d;
      rd_hi_q     <= rd_hi_d;
      hi_rd_q     <= hi_rd_d;
      dout_hold_q <= dout_hold_d;
    end
  end

  // Read data is live from the RAM the cycle after the strobe, then held.
  always_comb begin
    if (rd_pend_q) begin
      if (rd_hi_q)       cpu_dout = hi_rd_q;
      else if (rd_sel_q) cpu_dout = ram_q_a[15:8];
      else               cpu_dout = ram_q_a[7:0];
    end else begin
      cpu_dout = dout_hold_q;
    end
  end

  // Fixed priority: address load > vblank reload > data write > data read.
  always_comb begin
    reload_d     = reload_q;
    prio_en_d    = prio_en_q;
    byte_addr_d  = byte_addr_q;
    latch_d      = latch_q;
    rd_pend_d    = 1'b0;
    rd_sel_d     = rd_sel_q;
    rd_hi_d      = rd_hi_q;
    hi_rd_d      = hi_rd_q;
    dout_hold_d  = cpu_dout;
    ram_enable_a = 1'b0;
    ram_wren_a   = 1'b0;
    ram_data_a   = '0;
    hi_we        = 1'b0;
    hi_din       = '0;
    addr_ld      = oamadd_lo_we || oamadd_hi_we;
    vb_ld        = !addr_ld && vblank_start && !render_active;
    wr_go        = !addr_ld && !vb_ld && oamdata_we;
    rd_go        = !addr_ld && !vb_ld && !oamdata_we && oamdata_re;
    is_hi        = (byte_addr_q >= OAM_HI_BASE);
    if (addr_ld) begin
      if (oamadd_lo_we) reload_d[7:0] = cpu_din;
      if (oamadd_hi_we) begin
        reload_d[8] = cpu_din[0];
        prio_en_d   = cpu_din[7];
      end
      byte_addr_d = {reload_d, 1'b0};
    end else if (vb_ld) begin
      byte_addr_d = {reload_q, 1'b0};
    end else if (wr_go) begin
      byte_addr_d = byte_addr_q + BYTE_AW'(1);
      if (is_hi) begin
        hi_we  = !render_active;
        hi_din = render_active ? 8'h00 : cpu_din;
      end else if (!byte_addr_q[0]) begin
        latch_d = cpu_din;
      end else if (!render_active) begin
        ram_enable_a = 1'b1;
        ram_wren_a   = 1'b1;
        ram_data_a   = {cpu_din, latch_q};
      end
    end else if (rd_go) begin
      byte_addr_d  = byte_addr_q + BYTE_AW'(1);
      rd_pend_d    = 1'b1;
      rd_sel_d     = byte_addr_q[0];
      rd_hi_d      = is_hi;
      hi_rd_d      = hi_q;
      ram_enable_a = !is_hi;
    end
  end

  assign ram_address_a = byte_addr_q[WORD_AW:1];
  assign hi_addr       = byte_addr_q[4:0];
  assign start_idx     = prio_en_q ? reload_q[7:1] : '0;

  oam_scan_seq #(
    .NUM_OBJ(NUM_OBJ)
  ) u_scan (
    .clock         (clock),
    .reset         (reset),
    .line_start    (line_start),
    .start_idx     (start_idx),
    .obj_ready     (obj_ready),
    .ram_q_b       (ram_q_b),
    .ram_address_b (ram_address_b),
    .ram_enable_b  (ram_enable_b),
    .obj_valid     (obj_valid),
    .obj_index     (obj_index),
    .obj_data      (obj_data),
    .obj_last      (obj_last),
    .scan_busy     (scan_busy)
  );

endmodule

// File: tb/tb_oam_access_ctrl.sv
// Directed bench for oam_access_ctrl: CPU port-A/high-table vector table,
// then hand-written object scan sequences against simple RAM models.
module tb_oam_access_ctrl;

  localparam int unsigned NUM = 128;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        oamadd_lo_we = 0, oamadd_hi_we = 0, oamdata_we = 0, oamdata_re = 0;
  logic [7:0]  cpu_din = 0;
  logic [7:0]  cpu_dout;
  logic        render_active = 0, vblank_start = 0, line_start = 0;
  logic [7:0]  ram_address_a;
  logic [15:0] ram_data_a;
  logic        ram_enable_a, ram_wren_a;
  logic [15:0] ram_q_a;
  logic [4:0]  hi_addr;
  logic [7:0]  hi_din;
  logic        hi_we;
  logic [7:0]  hi_q;
  logic [6:0]  ram_address_b;
  logic        ram_enable_b;
  logic [31:0] ram_q_b;
  logic        obj_valid;
  logic        obj_ready = 0;
  logic [6:0]  obj_index;
  logic [31:0] obj_data;
  logic        obj_last, scan_busy;

  int n_cmp = 0;
  int n_fail = 0;

  logic [15:0] mem_a [256];
  logic [7:0]  hi_mem [32];

  oam_access_ctrl #(.NUM_OBJ(NUM)) dut (
    .clock(clock), .reset(reset),
    .oamadd_lo_we(oamadd_lo_we), .oamadd_hi_we(oamadd_hi_we),
    .oamdata_we(oamdata_we), .oamdata_re(oamdata_re),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .render_active(render_active), .vblank_start(vblank_start), .line_start(line_start),
    .ram_address_a(ram_address_a), .ram_data_a(ram_data_a),
    .ram_enable_a(ram_enable_a), .ram_wren_a(ram_wren_a), .ram_q_a(ram_q_a),
    .hi_addr(hi_addr), .hi_din(hi_din), .hi_we(hi_we), .hi_q(hi_q),
    .ram_address_b(ram_address_b), .ram_enable_b(ram_enable_b), .ram_q_b(ram_q_b),
    .obj_valid(obj_valid), .obj_ready(obj_ready), .obj_index(obj_index),
    .obj_data(obj_data), .obj_last(obj_last), .scan_busy(scan_busy)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] bdat(input logic [6:0] a);
    return {8'hC3, 1'b0, a, 9'h05A, ~a};
  endfunction

  // Synchronous RAM models: port A read-during-write keeps old q.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= (i == 3) ? 16'hBEEF : 16'h1000 + 16'(i);
      for (int i = 0; i < 32; i++) hi_mem[i] <= 8'h80 + 8'(i);
      ram_q_a <= '0;
      ram_q_b <= '0;
    end else begin
      if (ram_enable_a) begin
        if (ram_wren_a) mem_a[ram_address_a] <= ram_data_a;
        else            ram_q_a <= mem_a[ram_address_a];
      end
      if (hi_we) hi_mem[hi_addr] <= hi_din;
      if (ram_enable_b) ram_q_b <= bdat(ram_address_b);
    end
  end

  assign hi_q = hi_mem[hi_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic lo, hi, we, re, rend, vbl;
    logic [7:0] din;
    logic en, wr;
    logic [7:0] aa;
    logic [15:0] da;
    logic hw;
    logic [4:0] ha;
    logic [7:0] hd;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic lo, hi, we, re, rend, vbl, input logic [7:0] din,
                              input logic en, wr, input logic [7:0] aa, input logic [15:0] da,
                              input logic hw, input logic [4:0] ha, input logic [7:0] hd,
                              input logic [7:0] dout);
    vec_t v;
    v.lo = lo; v.hi = hi; v.we = we; v.re = re; v.rend = rend; v.vbl = vbl; v.din = din;
    v.en = en; v.wr = wr; v.aa = aa; v.da = da; v.hw = hw; v.ha = ha; v.hd = hd; v.dout = dout;
    return v;
  endfunction

  // Full scan with optional ready stall; checks order, data, last flag and length.
  task automatic run_scan(input logic [6:0] start, input int stall_from, input int stall_len,
                          input int exp_cycles);
    int k = 0;
    int vcyc = 0;
    logic [6:0] ei;
    @(posedge clock); #1 line_start = 1; obj_ready = 1;
    @(posedge clock); #1 line_start = 0;
    @(negedge clock);
    chk("scan_t1", {scan_busy, obj_valid, ram_enable_b, ram_address_b}, {1'b1, 1'b0, 1'b1, start});
    for (int cyc = 2; cyc < 400 && k < NUM; cyc++) begin
      @(posedge clock); #1 obj_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
      @(negedge clock);
      if (cyc == 2) chk("scan_first_valid", obj_valid, 1'b1);
      if (obj_valid) begin
        vcyc++;
        ei = start + 7'(k);
        chk($sformatf("scan_entry%0d", k), {obj_index, obj_data, obj_last},
            {ei, bdat(ei), (k == NUM - 1)});
        if (!obj_ready) chk("scan_stall_en", ram_enable_b, 1'b0);
        else k++;
      end
    end
    chk("scan_accepted", 64'(k), 64'(NUM));
    chk("scan_valid_cycles", 64'(vcyc), 64'(exp_cycles));
    @(posedge clock); #1;
    @(negedge clock);
    chk("scan_done", {obj_valid, scan_busy}, 2'b00);
  endtask

  initial begin
    //        lo hi we re rd vb din    en wr aa     da        hw ha     hd     dout
    vecs.push_back(mk(0,0,0,0,0,0,8'h00, 0,0,8'h00,16'h0000,0,5'h00,8'h00,8'h00));
    vecs.push_back(mk(1,0,0,0,0,0,8'h05, 0,0,8'h00,16'h0000,0,5'h00,8'h00,8'h00));
    vecs.push_back(mk(0,1,0,0,0,0,8'h00, 0,0,8'h05,16'h0000,0,5'h0A,8'h00,8'h00));
    vecs.push_back(mk(0,0,1,0,0,0,8'h11, 0,0,8'h05,16'h0000,0,5'h0A,8'h00,8'h00));
    vecs.push_back(mk(0,0,1,0,0,0,8'h22, 1,1,8'h05,16'h2211,0,5'h0B,8'h00,8'h00));
    vecs.push_back(mk(0,0,0,0,0,0,8'h00, 0,0,8'h06,16'h0000,0,5'h0C,8'h00,8'h00));
    vecs.push_back(mk(1,0,0,0,0,0,8'h00, 0,0,8'h06,16'h0000,0,5'h0C,8'h00,8'h00));
    vecs.push_back(mk(0,1,0,0,0,0,8'h01, 0,0,8'h00,16'h0000,0,5'h00,8'h00,8'h00));
    vecs.push_back(mk(0,0,1,0,0,0,8'hAB, 0,0,8'h00,16'h0000,1,5'h00,8'hAB,8'h00));
    vecs.push_back(mk(1,0,0,0,0,0,8'hF0, 0,0,8'h00,16'h0000,0,5'h01,8'h00,8'h00));
    vecs.push_back(mk(0,0,1,0,0,0,8'h55, 0,0,8'hF0,16'h0000,1,5'h00,8'h55,8'h00));
    vecs.push_back(mk(0,0,1,0,0,0,8'h66, 0,0,8'hF0,16'h0000,1,5'h01,8'h66,8'h00));
    vecs.push_back(mk(0,0,0,1,0,0,8'h00, 0,0,8'hF1,16'h0000,0,5'h02,8'h00,8'h00));
    vecs.push_back(mk(0,0,0,0,0,0,8'h00, 0,0,8'hF1,16'h0000,0,5'h03,8'h00,8'h82));
    vecs.push_back(mk(0,0,0,0,0,0,8'h00, 0,0,8'hF1,16'h0000,0,5'h03,8'h00,8'h82));
    vecs.push_back(mk(0,1,0,0,0,0,8'h00, 0,0,8'hF1,16'h0000,0,5'h03,8'h00,8'h82));
    vecs.push_back(mk(1,0,0,0,0,0,8'h02, 0,0,8'hF0,16'h0000,0,5'h00,8'h00,8'h82));
    vecs.push_back(mk(0,0,1,0,1,0,8'h77, 0,0,8'h02,16'h0000,0,5'h04,8'h00,8'h82));
    vecs.push_back(mk(0,0,1,0,1,0,8'h88, 0,0,8'h02,16'h0000,0,5'h05,8'h00,8'h82));
    vecs.push_back(mk(0,0,0,0,0,0,8'h00, 0,0,8'h03,16'h0000,0,5'h06,8'h00,8'h82));
    vecs.push_back(mk(0,0,0,0,1,1,8'h00, 0,0,8'h03,16'h0000,0,5'h06,8'h00,8'h82));
    vecs.push_back(mk(0,0,1,0,0,1,8'h99, 0,0,8'h03,16'h0000,0,5'h06,8'h00,8'h82));
    vecs.push_back(mk(0,0,0,0,0,0,8'h00, 0,0,8'h02,16'h0000,0,5'h04,8'h00,8'h82));
    vecs.push_back(mk(0,0,0,1,0,0,8'h00, 1,0,8'h02,16'h0000,0,5'h04,8'h00,8'h82));
    vecs.push_back(mk(0,0,1,0,0,0,8'h34, 1,1,8'h02,16'h3477,0,5'h05,8'h00,8'h02));
    vecs.push_back(mk(0,0,0,1,0,0,8'h00, 1,0,8'h03,16'h0000,0,5'h06,8'h00,8'h02));
    vecs.push_back(mk(1,0,1,0,0,0,8'h09, 0,0,8'h03,16'h0000,0,5'h07,8'h00,8'hEF));
    vecs.push_back(mk(0,0,0,1,0,0,8'h00, 1,0,8'h09,16'h0000,0,5'h12,8'h00,8'hEF));
    vecs.push_back(mk(0,0,1,1,0,0,8'h44, 1,1,8'h09,16'h4477,0,5'h13,8'h00,8'h09));
    vecs.push_back(mk(0,0,0,0,0,0,8'h00, 0,0,8'h0A,16'h0000,0,5'h14,8'h00,8'h09));
    vecs.push_back(mk(1,0,0,0,0,0,8'h03, 0,0,8'h0A,16'h0000,0,5'h14,8'h00,8'h09));
    vecs.push_back(mk(0,0,0,1,0,0,8'h00, 1,0,8'h03,16'h0000,0,5'h06,8'h00,8'h09));
    vecs.push_back(mk(0,0,0,1,0,0,8'h00, 1,0,8'h03,16'h0000,0,5'h07,8'h00,8'hEF));
    vecs.push_back(mk(0,0,0,0,0,0,8'h00, 0,0,8'h04,16'h0000,0,5'h08,8'h00,8'hBE));
    vecs.push_back(mk(0,1,0,0,0,0,8'h80, 0,0,8'h04,16'h0000,0,5'h08,8'h00,8'hBE));
    vecs.push_back(mk(1,0,0,0,0,0,8'h0A, 0,0,8'h03,16'h0000,0,5'h06,8'h00,8'hBE));
    vecs.push_back(mk(0,0,0,0,0,0,8'h00, 0,0,8'h0A,16'h0000,0,5'h14,8'h00,8'hBE));

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_outputs",
        {ram_enable_a, ram_wren_a, ram_address_a, hi_we, cpu_dout, obj_valid, obj_last,
         obj_index, scan_busy, ram_enable_b, ram_address_b},
        '0);
    @(posedge clock); #1 reset = 0;

    foreach (vecs[i]) begin
      @(posedge clock); #1;
      oamadd_lo_we  = vecs[i].lo;
      oamadd_hi_we  = vecs[i].hi;
      oamdata_we    = vecs[i].we;
      oamdata_re    = vecs[i].re;
      render_active = vecs[i].rend;
      vblank_start  = vecs[i].vbl;
      cpu_din       = vecs[i].din;
      @(negedge clock);
      chk($sformatf("row%0d", i),
          {ram_enable_a, ram_wren_a, ram_address_a, ram_data_a, hi_we, hi_addr, hi_din, cpu_dout},
          {vecs[i].en, vecs[i].wr, vecs[i].aa, vecs[i].da, vecs[i].hw, vecs[i].ha, vecs[i].hd,
           vecs[i].dout});
    end
    @(posedge clock); #1;
    {oamadd_lo_we, oamadd_hi_we, oamdata_we, oamdata_re, render_active, vblank_start} = '0;
    cpu_din = '0;

    // prio_en=1, reload=0x00A: rotation starts at entry 5
    run_scan(7'd5, 1000, 0, NUM);
    run_scan(7'd5, 40, 3, NUM + 3);

    // Restart mid-scan, then reset mid-scan
    @(posedge clock); #1 line_start = 1; obj_ready = 1;
    @(posedge clock); #1 line_start = 0;
    repeat (11) @(posedge clock);
    #1 line_start = 1;
    @(negedge clock);
    chk("restart_pre", {obj_valid, obj_index}, {1'b1, 7'd15});
    @(posedge clock); #1 line_start = 0;
    @(negedge clock);
    chk("restart_gap", {obj_valid, scan_busy}, 2'b01);
    @(posedge clock); #1;
    @(negedge clock);
    chk("restart_first", {obj_valid, obj_index, obj_data}, {1'b1, 7'd5, bdat(7'd5)});
    @(posedge clock); #1 reset = 1;
    @(posedge clock); #1 reset = 0;
    @(negedge clock);
    chk("reset_mid_scan", {obj_valid, scan_busy, ram_enable_b, ram_address_a, cpu_dout}, '0);

    // After reset prio_en is clear, so rotation starts at 0
    run_scan(7'd0, 1000, 0, NUM);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
